// File: rtl/output_trace_buffer.sv
// ---------------------------------------------------------------------------
// output_trace_buffer
//
// Purpose:
//   Picks the architecturally visible result of each retiring instruction
//   (register write data, store address or branch outcome), holds it on
//   OUTPUT_PORT and queues it in a FIFO. A consumer drains that FIFO through
//   a valid/ready handshake, so no result is lost while the consumer stalls.
//
// Handshake (OUT_VALID / OUT_READY):
//   OUT_VALID, OUT_DATA and OUT_STAMP are registered and describe the FIFO
//   head. A pop happens on a rising edge where OUT_VALID && OUT_READY. The
//   head outputs stay stable while OUT_VALID=1 and no pop occurs. OUT_READY
//   may be held high at any time. There is no bypass: an entry pushed into
//   an empty FIFO appears on OUT_VALID the cycle after its push edge.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   RF_WD, ALUOUT   candidate results (register write data, store address)
//   OPSrc, PCSrc    result select; PCSrc=2'b11 marks a conditional branch
//   Branch_Cond     branch taken flag
//   RETIRE          capture strobe
//   OUTPUT_PORT     last captured result
//   OUT_VALID/OUT_DATA/OUT_STAMP/OUT_READY  FIFO drain handshake
//   COUNT           FIFO occupancy
//   OVERFLOW        sticky flag, set when a capture is dropped
//   DROP_CNT        saturating count of dropped captures
//
// Optional feature:
//   OUTBUF_CYCLE_STAMP_EN - when defined, each entry carries the value of a
//   free-running cycle counter sampled on its push edge. When undefined,
//   OUT_STAMP is tied to zero.
// ---------------------------------------------------------------------------
module output_trace_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATA_WIDTH-1:0]      RF_WD,
    input  logic [DATA_WIDTH-1:0]      ALUOUT,
    input  logic [1:0]                 OPSrc,
    input  logic [1:0]                 PCSrc,
    input  logic                       Branch_Cond,
    input  logic                       RETIRE,
    output logic [DATA_WIDTH-1:0]      OUTPUT_PORT,
    output logic                       OUT_VALID,
    output logic [DATA_WIDTH-1:0]      OUT_DATA,
    output logic [CNT_WIDTH-1:0]       OUT_STAMP,
    input  logic                       OUT_READY,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       OVERFLOW,
    output logic [CNT_WIDTH-1:0]       DROP_CNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Registers
    logic [DATA_WIDTH-1:0] r_output_port;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    // Combinational
    logic                  w_sel_valid;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic [PTR_W-1:0]      w_wr_next;
    logic [PTR_W-1:0]      w_rd_next;
    logic [CNT_W-1:0]      w_count_next;
    logic                  w_head_bypass;
    logic [DATA_WIDTH-1:0] w_head_data_next;

    // Result selection; OPSrc=10 only captures for a conditional branch.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        if (RETIRE) begin
            case (OPSrc)
                2'b00: begin
                    w_sel_valid = 1'b1;
                    w_sel_data  = RF_WD;
                end
                2'b01: begin
                    w_sel_valid = 1'b1;
                    w_sel_data  = ALUOUT;
                end
                2'b10: begin
                    if (PCSrc == 2'b11) begin
                        w_sel_valid = 1'b1;
                        w_sel_data  = DATA_WIDTH'(Branch_Cond);
                    end
                end
                default: begin
                    w_sel_valid = 1'b0;
                end
            endcase
        end
    end

    assign w_pop  = r_out_valid & OUT_READY;
    assign w_full = (r_count == FULL_CNT);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push = w_sel_valid & (~w_full | w_pop);
    assign w_drop = w_sel_valid & ~w_push;

    assign w_wr_next = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    assign w_rd_next = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // The head registers look one entry ahead. If the next head slot is the
    // one being written on this edge, the memory does not hold it yet, so
    // the incoming value is forwarded into the head register instead.
    assign w_head_bypass    = w_push && (r_wr_ptr == w_rd_next);
    assign w_head_data_next = w_head_bypass ? w_sel_data : r_mem[w_rd_next];

    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_mem[r_wr_ptr] <= w_sel_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_output_port <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_overflow    <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_sel_valid) begin
                r_output_port <= w_sel_data;
            end
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != '0);
            // Head data reads as zero while the FIFO is empty.
            r_out_data  <= (w_count_next != '0) ? w_head_data_next : '0;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef OUTBUF_CYCLE_STAMP_EN
    logic [CNT_WIDTH-1:0] r_cycle;
    logic [CNT_WIDTH-1:0] r_stamp_mem [DEPTH];
    logic [CNT_WIDTH-1:0] r_out_stamp;
    logic [CNT_WIDTH-1:0] w_head_stamp_next;

    // Same look-ahead as the data path; a pushed entry is stamped with the
    // counter value before this edge's increment.
    assign w_head_stamp_next = w_head_bypass ? r_cycle : r_stamp_mem[w_rd_next];

    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_stamp_mem[r_wr_ptr] <= r_cycle;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cycle     <= '0;
            r_out_stamp <= '0;
        end else begin
            r_cycle     <= r_cycle + CNT_WIDTH'(1);
            r_out_stamp <= (w_count_next != '0) ? w_head_stamp_next : '0;
        end
    end

    assign OUT_STAMP = r_out_stamp;
`else
    assign OUT_STAMP = '0;
`endif

    assign OUTPUT_PORT = r_output_port;
    assign OUT_VALID   = r_out_valid;
    assign OUT_DATA    = r_out_data;
    assign COUNT       = r_count;
    assign OVERFLOW    = r_overflow;
    assign DROP_CNT    = r_drop_cnt;

endmodule

// File: doc/output_trace_buffer.md
# output_trace_buffer

Registered, buffered successor to the CPU's output-port selector. On each retiring instruction it selects the architecturally visible result (register write data, store address, or branch outcome), holds it on `OUTPUT_PORT`, and pushes it into a parametrised FIFO. The testbench or debug host drains that FIFO through a valid/ready handshake. It sits between the multicycle datapath/control and the top-level output pins, so no result is lost when the checker stalls.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of selected result, `OUTPUT_PORT` and FIFO data.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `CNT_WIDTH`, 16: width of drop counter and cycle stamp.

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RF_WD`  in  DATA_WIDTH  register-file write data.
- `ALUOUT`  in  DATA_WIDTH  ALU result (store address).
- `OPSrc`  in  2  result select.
- `PCSrc`  in  2  PC source; `2'b11` = conditional branch.
- `Branch_Cond`  in  1  branch taken.
- `RETIRE`  in  1  instruction completes this cycle; capture strobe.
- `OUTPUT_PORT`  out  DATA_WIDTH  last captured result (registered).
- `OUT_VALID`  out  1  FIFO head valid.
- `OUT_DATA`  out  DATA_WIDTH  FIFO head data.
- `OUT_STAMP`  out  CNT_WIDTH  FIFO head cycle stamp (0 when feature off).
- `OUT_READY`  in  1  consumer accepts head.
- `COUNT`  out  $clog2(DEPTH)+1  current occupancy.
- `OVERFLOW`  out  1  sticky: a capture was dropped.
- `DROP_CNT`  out  CNT_WIDTH  dropped captures, saturating.

## Operation
- Selection, evaluated only when `RETIRE`=1:
  - `OPSrc`=00 → `RF_WD`.
  - `OPSrc`=01 → `ALUOUT`.
  - `OPSrc`=10 with `PCSrc`=11 → `Branch_Cond` zero-extended to `DATA_WIDTH`.
  - `OPSrc`=10 with `PCSrc`≠11, or `OPSrc`=11 → no capture.
- No capture: `OUTPUT_PORT`, FIFO and counters hold.
- Valid capture: `OUTPUT_PORT` ← selected value, and a push is requested.
- Push:
  - Accepted if not full, or if a pop occurs on the same edge.
  - Otherwise the entry is dropped: `OVERFLOW` ← 1 and `DROP_CNT` increments, saturating at all-ones.
  - `OUTPUT_PORT` still updates on a drop.
- Pop: occurs when `OUT_VALID`&&`OUT_READY`.
- Pointers wrap modulo `DEPTH`.
- `COUNT`:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Empty FIFO with push and `OUT_READY`=1: no bypass. The entry is stored; `OUT_VALID` rises the next cycle.
- `OVERFLOW` and `DROP_CNT` clear only on `RST`.

## Timing
- Reset values:
  - `OUTPUT_PORT`=0, `OUT_VALID`=0, `OUT_DATA`=0, `OUT_STAMP`=0.
  - `COUNT`=0, `OVERFLOW`=0, `DROP_CNT`=0.
  - Read/write pointers = 0; cycle counter = 0.
- `RST` overrides push and pop on the same edge. Reset mid-operation discards all FIFO contents; no entry survives.
- Capture latency: edge N samples inputs; `OUTPUT_PORT` and `COUNT` reflect the capture after edge N.
- Write-to-`OUT_VALID` latency: 1 cycle. `OUT_DATA`/`OUT_STAMP` are registered head outputs and stable while `OUT_VALID`=1 and no pop occurs.
- Full (`COUNT`=`DEPTH`) with push and pop on the same edge: both happen, no drop, `COUNT` stays `DEPTH`.
- Back-to-back `RETIRE` every cycle with `OUT_READY` held high: sustained throughput of 1 entry/cycle, no drops.
- Consumer may hold `OUT_READY` high at any time; a pop requires `OUT_VALID`.

## Configuration
- `OUTBUF_CYCLE_STAMP_EN` defined:
  - A free-running `CNT_WIDTH` cycle counter increments every non-reset cycle and wraps to 0 after all-ones.
  - Each pushed entry stores the counter value sampled on its push edge (pre-increment); `OUT_STAMP` presents the head's stamp.
- Not defined: no counter and no stamp storage; `OUT_STAMP` is tied to 0.

## Test plan
- Reset, then `RETIRE`=1, `OPSrc`=00, `RF_WD`=0x1234 → next cycle `OUTPUT_PORT`=0x1234, `COUNT`=1, `OUT_VALID`=1, `OUT_DATA`=0x1234.
- `OPSrc`=10, `PCSrc`=11, `Branch_Cond`=1, then `Branch_Cond`=0 → entries 0x1 then 0x0. Then `OPSrc`=10, `PCSrc`=01 → `OUTPUT_PORT` holds 0x0 and `COUNT` is unchanged.
- `OUT_READY`=0, `DEPTH`+3 captures → `COUNT`=`DEPTH`, `OVERFLOW`=1, `DROP_CNT`=3. Then drain → the first `DEPTH` values come out in order.
- Full FIFO, `RETIRE`=1 and `OUT_READY`=1 on the same edge → `COUNT` stays `DEPTH`, `DROP_CNT` unchanged, new value at the tail.
- 5 entries queued, assert `RST` one cycle → all outputs 0 next cycle. A subsequent capture of 0xAA is the first value popped.
- With `OUTBUF_CYCLE_STAMP_EN`: captures on cycles 3 and 7 after reset release → `OUT_STAMP` = 3, then 7.
